id_ex_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core.
- Captures decode-stage control and operands each cycle.
- Holds them on a global stall.
- Inserts a NOP bubble when the decode-stage load-use hazard flag (load_use) is asserted, or when EX resolves a taken branch (flush).
- Its E_MemtoReg/E_Rt outputs feed the load-use hazard detector. Its saturating bubble/flush counters provide performance statistics.

---
 rtl/id_ex_reg_pkg.sv | 70 +++++++
 rtl/id_ex_reg_sat_counter.sv | 35 +++
 rtl/id_ex_reg.sv | 136 +++++++++++++
 tb/tb_id_ex_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
package id_ex_reg_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ALU_CTRL_W = 4;
   localparam int unsigned REG_ADDR_W = 5;

   // Decoded control bits carried from ID into EX.
   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  branch;
      logic                  alu_src;
      logic                  reg_dst;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
   } ex_ctrl_t;

   // All control bits low: no register write, no memory access, no branch.
   localparam ex_ctrl_t NOP_CTRL = '0;

   // Complete contents of the ID/EX register.
   typedef struct packed {
      logic                  valid;
      logic [DATA_W-1:0]     pc;
      ex_ctrl_t              ctrl;
      logic [DATA_W-1:0]     rd1;
      logic [DATA_W-1:0]     rd2;
      logic [DATA_W-1:0]     imm;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
   } id_ex_t;

   // What the register does in a given cycle (reset is handled separately).
   typedef enum logic [1:0] {
      ActCapture,
      ActHold,
      ActBubble,
      ActFlush
   } id_ex_act_t;

   // Bubble contents. mem_to_reg = 0 and rt = 0 guarantee a bubble never
   // re-triggers the load-use detector on the following cycle.
   function automatic id_ex_t nop_entry(input logic [DATA_W-1:0] pc);
      id_ex_t e;
      e      = '0;
      e.ctrl = NOP_CTRL;
      e.pc   = pc;
      return e;
   endfunction

   // Priority: flush > stall > load_use > capture.
   function automatic id_ex_act_t select_action(input logic flush,
                                                input logic stall,
                                                input logic load_use);
      id_ex_act_t act;
      if (flush) begin
         act = ActFlush;
      end else if (stall) begin
         act = ActHold;
      end else if (load_use) begin
         act = ActBubble;
      end else begin
         act = ActCapture;
      end
      return act;
   endfunction

endpackage

// File: rtl/id_ex_reg_sat_counter.sv
// Saturating up-counter with synchronous reset; holds when inc is low.
module id_ex_reg_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Increment unless already at the maximum; never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != MAX_VAL)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage control and operands,
// holds on stall, inserts bubbles on load-use and flush, and counts both.
module id_ex_reg
   import id_ex_reg_pkg::*;
#(
   parameter int unsigned       CNT_W  = 16,
   parameter logic [DATA_W-1:0] NOP_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  load_use,
   input  logic                  D_valid,
   input  logic [DATA_W-1:0]     D_PC,
   input  logic                  D_RegWrite,
   input  logic                  D_MemtoReg,
   input  logic                  D_MemWrite,
   input  logic                  D_Branch,
   input  logic                  D_ALUSrc,
   input  logic                  D_RegDst,
   input  logic [ALU_CTRL_W-1:0] D_ALUCtrl,
   input  logic [DATA_W-1:0]     D_RD1,
   input  logic [DATA_W-1:0]     D_RD2,
   input  logic [DATA_W-1:0]     D_Imm,
   input  logic [REG_ADDR_W-1:0] D_Rs,
   input  logic [REG_ADDR_W-1:0] D_Rt,
   input  logic [REG_ADDR_W-1:0] D_Rd,
   output logic                  E_valid,
   output logic [DATA_W-1:0]     E_PC,
   output logic                  E_RegWrite,
   output logic                  E_MemtoReg,
   output logic                  E_MemWrite,
   output logic                  E_Branch,
   output logic                  E_ALUSrc,
   output logic                  E_RegDst,
   output logic [ALU_CTRL_W-1:0] E_ALUCtrl,
   output logic [DATA_W-1:0]     E_RD1,
   output logic [DATA_W-1:0]     E_RD2,
   output logic [DATA_W-1:0]     E_Imm,
   output logic [REG_ADDR_W-1:0] E_Rs,
   output logic [REG_ADDR_W-1:0] E_Rt,
   output logic [REG_ADDR_W-1:0] E_Rd,
   output logic [CNT_W-1:0]      bubble_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   id_ex_act_t act;
   id_ex_t     d_entry;
   id_ex_t     ex_d;
   id_ex_t     ex_q;
   logic       bubble_inc;
   logic       flush_inc;

   // Bundle the decode-stage inputs into one register image.
   always_comb begin
      d_entry                = '0;
      d_entry.valid          = D_valid;
      d_entry.pc             = D_PC;
      d_entry.ctrl.reg_write = D_RegWrite;
      d_entry.ctrl.mem_to_reg = D_MemtoReg;
      d_entry.ctrl.mem_write = D_MemWrite;
      d_entry.ctrl.branch    = D_Branch;
      d_entry.ctrl.alu_src   = D_ALUSrc;
      d_entry.ctrl.reg_dst   = D_RegDst;
      d_entry.ctrl.alu_ctrl  = D_ALUCtrl;
      d_entry.rd1            = D_RD1;
      d_entry.rd2            = D_RD2;
      d_entry.imm            = D_Imm;
      d_entry.rs             = D_Rs;
      d_entry.rt             = D_Rt;
      d_entry.rd             = D_Rd;
   end

   // Resolve the per-cycle action and the next register contents.
   always_comb begin
      act  = select_action(flush, stall, load_use);
      ex_d = ex_q;
      unique case (act)
         ActFlush:   ex_d = nop_entry(NOP_PC);
         ActBubble:  ex_d = nop_entry(NOP_PC);
         ActHold:    ex_d = ex_q;
         ActCapture: ex_d = d_entry;
         default:    ex_d = ex_q;
      endcase
   end

   // Counters only advance on the action that actually took effect, so a
   // load_use masked by stall or flush is not counted.
   assign bubble_inc = (act == ActBubble);
   assign flush_inc  = (act == ActFlush);

   // E_ register; reset wins over stall and everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= nop_entry(NOP_PC);
      end else begin
         ex_q <= ex_d;
      end
   end

   id_ex_reg_sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc),
      .count (bubble_cnt)
   );

   id_ex_reg_sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

   assign E_valid    = ex_q.valid;
   assign E_PC       = ex_q.pc;
   assign E_RegWrite = ex_q.ctrl.reg_write;
   assign E_MemtoReg = ex_q.ctrl.mem_to_reg;
   assign E_MemWrite = ex_q.ctrl.mem_write;
   assign E_Branch   = ex_q.ctrl.branch;
   assign E_ALUSrc   = ex_q.ctrl.alu_src;
   assign E_RegDst   = ex_q.ctrl.reg_dst;
   assign E_ALUCtrl  = ex_q.ctrl.alu_ctrl;
   assign E_RD1      = ex_q.rd1;
   assign E_RD2      = ex_q.rd2;
   assign E_Imm      = ex_q.imm;
   assign E_Rs       = ex_q.rs;
   assign E_Rt       = ex_q.rt;
   assign E_Rd       = ex_q.rd;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: the driver pushes hand-computed expected
// E_ state per cycle; a monitor pops and compares after each rising edge.
module tb_id_ex_reg;

   localparam int unsigned CW    = 2;
   localparam logic [31:0] NOPPC = 32'hBFC0_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        rw;
      logic        m2r;
      logic        mw;
      logic        br;
      logic        alusrc;
      logic        regdst;
      logic [3:0]  aluctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } fields_t;

   typedef struct {
      string         name;
      fields_t       f;
      logic [CW-1:0] bub;
      logic [CW-1:0] fl;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   logic        clk, rst, stall, flush, load_use;
   logic        D_valid, D_RegWrite, D_MemtoReg, D_MemWrite, D_Branch, D_ALUSrc, D_RegDst;
   logic [31:0] D_PC, D_RD1, D_RD2, D_Imm;
   logic [3:0]  D_ALUCtrl;
   logic [4:0]  D_Rs, D_Rt, D_Rd;
   logic        E_valid, E_RegWrite, E_MemtoReg, E_MemWrite, E_Branch, E_ALUSrc, E_RegDst;
   logic [31:0] E_PC, E_RD1, E_RD2, E_Imm;
   logic [3:0]  E_ALUCtrl;
   logic [4:0]  E_Rs, E_Rt, E_Rd;
   logic [CW-1:0] bubble_cnt, flush_cnt;
   fields_t     act;

   id_ex_reg #(
      .CNT_W  (CW),
      .NOP_PC (NOPPC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .load_use   (load_use),
      .D_valid    (D_valid),
      .D_PC       (D_PC),
      .D_RegWrite (D_RegWrite),
      .D_MemtoReg (D_MemtoReg),
      .D_MemWrite (D_MemWrite),
      .D_Branch   (D_Branch),
      .D_ALUSrc   (D_ALUSrc),
      .D_RegDst   (D_RegDst),
      .D_ALUCtrl  (D_ALUCtrl),
      .D_RD1      (D_RD1),
      .D_RD2      (D_RD2),
      .D_Imm      (D_Imm),
      .D_Rs       (D_Rs),
      .D_Rt       (D_Rt),
      .D_Rd       (D_Rd),
      .E_valid    (E_valid),
      .E_PC       (E_PC),
      .E_RegWrite (E_RegWrite),
      .E_MemtoReg (E_MemtoReg),
      .E_MemWrite (E_MemWrite),
      .E_Branch   (E_Branch),
      .E_ALUSrc   (E_ALUSrc),
      .E_RegDst   (E_RegDst),
      .E_ALUCtrl  (E_ALUCtrl),
      .E_RD1      (E_RD1),
      .E_RD2      (E_RD2),
      .E_Imm      (E_Imm),
      .E_Rs       (E_Rs),
      .E_Rt       (E_Rt),
      .E_Rd       (E_Rd),
      .bubble_cnt (bubble_cnt),
      .flush_cnt  (flush_cnt)
   );

   assign act = {E_valid, E_PC, E_RegWrite, E_MemtoReg, E_MemWrite, E_Branch, E_ALUSrc,
                 E_RegDst, E_ALUCtrl, E_RD1, E_RD2, E_Imm, E_Rs, E_Rt, E_Rd};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every entry pushed before an edge is compared just after it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (act !== e.f || bubble_cnt !== e.bub || flush_cnt !== e.fl) begin
            errors++;
            $display("FAIL %s: got E=%h bub=%0d fl=%0d, expected E=%h bub=%0d fl=%0d",
                     e.name, act, bubble_cnt, flush_cnt, e.f, e.bub, e.fl);
         end
      end
   end

   // Hand-built vectors.
   fields_t v_nop, v_any, v_40, v_lw, v_add, v_100, v_inv;

   initial begin
      v_nop    = '0;
      v_nop.pc = NOPPC;
      v_any = '{valid: 1'b1, pc: 32'h0000_1234, rw: 1'b1, m2r: 1'b1, mw: 1'b1, br: 1'b1,
                alusrc: 1'b1, regdst: 1'b1, aluctrl: 4'hA, rd1: 32'h1111_1111,
                rd2: 32'h2222_2222, imm: 32'hFFFF_FFF0, rs: 5'd3, rt: 5'd4, rd: 5'd5};
      v_40       = '0;
      v_40.valid = 1'b1;
      v_40.pc    = 32'h40;
      v_40.rw    = 1'b1;
      v_lw = '{valid: 1'b1, pc: 32'h44, rw: 1'b1, m2r: 1'b1, mw: 1'b0, br: 1'b0,
               alusrc: 1'b1, regdst: 1'b0, aluctrl: 4'h2, rd1: 32'h0000_1000,
               rd2: 32'h0, imm: 32'h8, rs: 5'd29, rt: 5'd8, rd: 5'd0};
      v_add = '{valid: 1'b1, pc: 32'h48, rw: 1'b1, m2r: 1'b0, mw: 1'b0, br: 1'b0,
                alusrc: 1'b0, regdst: 1'b1, aluctrl: 4'h2, rd1: 32'h5, rd2: 32'h6,
                imm: 32'h0, rs: 5'd8, rt: 5'd9, rd: 5'd10};
      v_100 = '{valid: 1'b1, pc: 32'h100, rw: 1'b0, m2r: 1'b0, mw: 1'b1, br: 1'b0,
                alusrc: 1'b1, regdst: 1'b0, aluctrl: 4'h6, rd1: 32'hCAFE_0000,
                rd2: 32'h0000_BEEF, imm: 32'h10, rs: 5'd1, rt: 5'd2, rd: 5'd0};
      v_inv       = '0;
      v_inv.pc    = 32'h80;
      v_inv.rw    = 1'b1;
      v_inv.rt    = 5'd7;
   end

   // Apply one cycle of stimulus and, if chk, queue the expected result.
   task automatic cyc(input string name, input fields_t d, input logic r, input logic f,
                      input logic s, input logic lu, input bit chk, input fields_t ef,
                      input int eb, input int efl);
      exp_t e;
      @(negedge clk);
      rst        = r;
      flush      = f;
      stall      = s;
      load_use   = lu;
      D_valid    = d.valid;
      D_PC       = d.pc;
      D_RegWrite = d.rw;
      D_MemtoReg = d.m2r;
      D_MemWrite = d.mw;
      D_Branch   = d.br;
      D_ALUSrc   = d.alusrc;
      D_RegDst   = d.regdst;
      D_ALUCtrl  = d.aluctrl;
      D_RD1      = d.rd1;
      D_RD2      = d.rd2;
      D_Imm      = d.imm;
      D_Rs       = d.rs;
      D_Rt       = d.rt;
      D_Rd       = d.rd;
      if (chk) begin
         e.name = name;
         e.f    = ef;
         e.bub  = CW'(eb);
         e.fl   = CW'(efl);
         sbq.push_back(e);
      end
   endtask

   initial begin
      {rst, flush, stall, load_use} = 4'b1000;
      {D_valid, D_RegWrite, D_MemtoReg, D_MemWrite, D_Branch, D_ALUSrc, D_RegDst} = '0;
      {D_PC, D_RD1, D_RD2, D_Imm, D_ALUCtrl, D_Rs, D_Rt, D_Rd} = '0;
      #1;

      // Reset with arbitrary D_ values, then first capture.
      cyc("rst0",      v_any, 1, 0, 0, 0, 1, v_nop, 0, 0);
      cyc("rst1",      v_any, 1, 0, 0, 1, 1, v_nop, 0, 0);
      cyc("cap_40",    v_40,  0, 0, 0, 0, 1, v_40,  0, 0);

      // Load-use bubble.
      cyc("cap_lw",    v_lw,  0, 0, 0, 0, 1, v_lw,  0, 0);
      cyc("lu_bubble", v_add, 0, 0, 0, 1, 1, v_nop, 1, 0);
      cyc("add_again", v_add, 0, 0, 0, 0, 1, v_add, 1, 0);

      // Stall hold, load_use ignored while stalled.
      cyc("cap_100",   v_100, 0, 0, 0, 0, 1, v_100, 1, 0);
      cyc("stall0",    v_any, 0, 0, 1, 1, 1, v_100, 1, 0);
      cyc("stall1",    v_lw,  0, 0, 1, 1, 1, v_100, 1, 0);
      cyc("stall2",    v_add, 0, 0, 1, 1, 1, v_100, 1, 0);
      cyc("post_lu",   v_add, 0, 0, 0, 1, 1, v_nop, 2, 0);
      cyc("post_cap",  v_add, 0, 0, 0, 0, 1, v_add, 2, 0);

      // Flush beats stall and load_use.
      cyc("flush_all", v_any, 0, 1, 1, 1, 1, v_nop, 2, 1);
      cyc("cap_any",   v_any, 0, 0, 0, 0, 1, v_any, 2, 1);
      cyc("flush_st",  v_lw,  0, 1, 1, 0, 1, v_nop, 2, 2);

      // Saturation (CNT_W = 2), bubbles with D_valid = 0 still count.
      cyc("rst_sat",   v_any, 1, 0, 0, 0, 1, v_nop, 0, 0);
      cyc("sat_b1",    v_inv, 0, 0, 0, 1, 1, v_nop, 1, 0);
      cyc("sat_b2",    v_inv, 0, 0, 0, 1, 1, v_nop, 2, 0);
      cyc("sat_b3",    v_inv, 0, 0, 0, 1, 1, v_nop, 3, 0);
      cyc("sat_b4",    v_inv, 0, 0, 0, 1, 1, v_nop, 3, 0);
      cyc("sat_b5",    v_inv, 0, 0, 0, 1, 1, v_nop, 3, 0);
      cyc("sat_f1",    v_any, 0, 1, 0, 0, 1, v_nop, 3, 1);
      cyc("sat_f2",    v_any, 0, 1, 0, 0, 1, v_nop, 3, 2);
      cyc("sat_f3",    v_any, 0, 1, 0, 0, 1, v_nop, 3, 3);
      cyc("sat_f4",    v_any, 0, 1, 1, 1, 1, v_nop, 3, 3);

      // Reset in the middle of a stall.
      cyc("rst_ms",    v_any, 1, 0, 0, 0, 1, v_nop, 0, 0);
      cyc("ms_b1",     v_add, 0, 0, 0, 1, 1, v_nop, 1, 0);
      cyc("ms_b2",     v_add, 0, 0, 0, 1, 1, v_nop, 2, 0);
      cyc("ms_cap",    v_40,  0, 0, 0, 0, 1, v_40,  2, 0);
      cyc("ms_hold",   v_any, 0, 0, 1, 1, 1, v_40,  2, 0);
      cyc("ms_rst",    v_any, 1, 0, 1, 1, 1, v_nop, 0, 0);
      cyc("ms_after",  v_add, 0, 0, 0, 0, 1, v_add, 0, 0);

      // Let the monitor drain the scoreboard, bounded.
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
